// File: rtl/apb_uart_host_arb_pkg.sv
// Shared definitions for the APB host-side arbiter of the UART register block.
package apb_uart_host_arb_pkg;

  localparam int unsigned APB_ADDR_WIDTH = 12;
  localparam int unsigned APB_DATA_WIDTH = 32;
  localparam int unsigned HARB_NREQ_MAX  = 4;

  typedef enum logic [1:0] {
    HARB_IDLE   = 2'd0,
    HARB_SETUP  = 2'd1,
    HARB_ACCESS = 2'd2
  } harb_state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_uart_host_arb_rr_arb.sv
// Combinational round-robin picker: nearest requester after last_owner wins.
module apb_rr_arb
  import apb_uart_host_arb_pkg::*;
#(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned IDX_W = idx_width(NREQ)
) (
  input  logic [NREQ-1:0]  req_masked,
  input  logic [IDX_W-1:0] last_owner,
  output logic [NREQ-1:0]  win,
  output logic [IDX_W-1:0] win_idx
);

  logic [IDX_W-1:0] cand;

  // Scan farthest-first so the closest candidate overwrites and ends up winning.
  always_comb begin
    win     = '0;
    win_idx = '0;
    cand    = '0;
    for (int unsigned k = NREQ; k >= 1; k--) begin
      cand = IDX_W'((32'(last_owner) + k) % NREQ);
      if (req_masked[cand]) begin
        win       = '0;
        win[cand] = 1'b1;
        win_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/apb_uart_host_arb.sv
// Round-robin APB master sharing the UART register block's slave port among NREQ requesters.
module apb_uart_host_arb
  import apb_uart_host_arb_pkg::*;
#(
  parameter int unsigned NREQ   = 2,
  parameter int unsigned ADDR_W = APB_ADDR_WIDTH,
  parameter int unsigned DATA_W = APB_DATA_WIDTH
) (
  input  logic                     pclk,
  input  logic                     presetn,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          req_write,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          ack,
  output logic [DATA_W-1:0]        rdata,
  output logic [NREQ-1:0]          grant,
  output logic                     psel,
  output logic                     penable,
  output logic                     pwrite,
  output logic [ADDR_W-1:0]        paddr,
  output logic [DATA_W-1:0]        pwdata,
  input  logic [DATA_W-1:0]        prdata
);

  localparam int unsigned IDX_W = idx_width(NREQ);

  harb_state_e      state, state_nxt;
  logic [IDX_W-1:0] last_owner;
  logic [NREQ-1:0]  req_masked, win;
  logic [IDX_W-1:0] win_idx;
  logic             load;

  assign ack   = (state == HARB_ACCESS) ? grant : '0;
  assign rdata = prdata;

  // The owner's req is still high on the edge that acks it; it must not re-win there.
  assign req_masked = req & ~ack;
  assign load       = ((state == HARB_IDLE) || (state == HARB_ACCESS)) && (|win);

  apb_rr_arb #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_arb (
    .req_masked (req_masked),
    .last_owner (last_owner),
    .win        (win),
    .win_idx    (win_idx)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      HARB_IDLE:   if (load) state_nxt = HARB_SETUP;
      HARB_SETUP:  state_nxt = HARB_ACCESS;
      HARB_ACCESS: state_nxt = load ? HARB_SETUP : HARB_IDLE;
      default:     state_nxt = HARB_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state      <= HARB_IDLE;
      psel       <= 1'b0;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      paddr      <= '0;
      pwdata     <= '0;
      grant      <= '0;
      last_owner <= IDX_W'(NREQ - 1);
    end else begin
      state   <= state_nxt;
      psel    <= (state_nxt != HARB_IDLE);
      penable <= (state_nxt == HARB_ACCESS);
      if (load) begin
        grant      <= win;
        last_owner <= win_idx;
        pwrite     <= req_write[win_idx];
        paddr      <= req_addr[win_idx*ADDR_W +: ADDR_W];
        pwdata     <= req_wdata[win_idx*DATA_W +: DATA_W];
      end else if (state == HARB_ACCESS) begin
        grant <= '0;
      end
    end
  end

endmodule

// File: tb/tb_apb_uart_host_arb.sv
// Directed and randomized checks of apb_uart_host_arb against a transaction-level model.
module tb_apb_uart_host_arb;

  localparam int unsigned NREQ = 3;
  localparam int unsigned AW   = 12;
  localparam int unsigned DW   = 32;

  logic                 pclk = 1'b0;
  logic                 presetn = 1'b1;
  logic [NREQ-1:0]      req, req_write;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*DW-1:0]   req_wdata;
  logic [NREQ-1:0]      ack, grant;
  logic [DW-1:0]        rdata, pwdata, prdata;
  logic                 psel, penable, pwrite;
  logic [AW-1:0]        paddr;

  always #5 pclk = ~pclk;

  apb_uart_host_arb #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) dut (
    .pclk(pclk), .presetn(presetn), .req(req), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .ack(ack), .rdata(rdata),
    .grant(grant), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata)
  );

  // Slave: 16-word register file, reset to 0xC1+index, read data registered at SETUP.
  logic [31:0] mem [16];
  always @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'hC1 + 32'(i);
      prdata <= '0;
    end else begin
      if (psel && !penable && !pwrite) prdata <= mem[paddr[5:2]];
      if (psel && penable && pwrite) mem[paddr[5:2]] <= pwdata;
    end
  end

  int checks = 0;
  int fails  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic do_reset();
    req = '0;
    #1 presetn = 1'b0;
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    presetn = 1'b1;
  endtask

  task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_write[i]          = w;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  // Reference model state (transaction level)
  int              m_owner, m_phase, m_last, just_acked, winner, cidx, k;
  logic            m_write;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_wdata;
  logic [31:0]     ref_mem [16];
  logic [NREQ-1:0] pend, exp_oh;
  int              cnt [NREQ];
  logic            prev_pen;

  initial begin
    req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    do_reset();
    check("rst_psel", 32'(psel), 32'd0);
    check("rst_penable", 32'(penable), 32'd0);
    check("rst_pwrite", 32'(pwrite), 32'd0);
    check("rst_paddr", 32'(paddr), 32'd0);
    check("rst_pwdata", pwdata, 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);

    // Single write
    set_req(0, 1'b1, 12'h004, 32'h5A);
    req = 3'b001;
    tick();
    check("wr_setup_psel", 32'(psel), 32'd1);
    check("wr_setup_penable", 32'(penable), 32'd0);
    check("wr_setup_paddr", 32'(paddr), 32'h004);
    check("wr_setup_pwdata", pwdata, 32'h5A);
    check("wr_setup_pwrite", 32'(pwrite), 32'd1);
    check("wr_setup_grant", 32'(grant), 32'b001);
    check("wr_setup_ack", 32'(ack), 32'd0);
    tick();
    check("wr_access_psel", 32'(psel), 32'd1);
    check("wr_access_penable", 32'(penable), 32'd1);
    check("wr_access_ack", 32'(ack), 32'b001);
    req = '0;
    tick();
    check("wr_idle_psel", 32'(psel), 32'd0);
    check("wr_idle_ack", 32'(ack), 32'd0);
    check("wr_idle_paddr_hold", 32'(paddr), 32'h004);
    check("wr_slave_mem", mem[1], 32'h5A);

    // Single read from requester 1
    set_req(1, 1'b0, 12'h008, 32'h0);
    req = 3'b010;
    tick();
    check("rd_setup_psel", 32'(psel), 32'd1);
    check("rd_setup_paddr", 32'(paddr), 32'h008);
    check("rd_setup_pwrite", 32'(pwrite), 32'd0);
    check("rd_setup_grant", 32'(grant), 32'b010);
    tick();
    check("rd_ack", 32'(ack), 32'b010);
    check("rd_rdata", rdata, 32'h000000C3);
    req = '0;
    tick();
    check("rd_after_psel", 32'(psel), 32'd0);

    // Contention from reset
    do_reset();
    set_req(0, 1'b1, 12'h010, 32'h11);
    set_req(1, 1'b1, 12'h014, 32'h22);
    req = 3'b011;
    for (int c = 1; c <= 4; c++) begin
      tick();
      check("cont_psel", 32'(psel), 32'd1);
      check("cont_grant", 32'(grant), (c <= 2) ? 32'b001 : 32'b010);
      check("cont_ack", 32'(ack), (c == 2) ? 32'b001 : (c == 4) ? 32'b010 : 32'd0);
      if (c == 2) req[0] = 1'b0;
      if (c == 4) req = '0;
    end
    tick();
    check("cont_end_psel", 32'(psel), 32'd0);
    check("cont_end_grant", 32'(grant), 32'd0);

    // Fairness, all three continuously requesting
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      set_req(i, 1'b1, AW'(12'h020 + 4 * i), 32'(i));
      cnt[i] = 0;
    end
    req = 3'b111;
    k = 0;
    for (int c = 1; c <= 24; c++) begin
      tick();
      if (ack != '0) begin
        check("fair_order", 32'(ack), 32'(1) << (k % 3));
        for (int i = 0; i < NREQ; i++) if (ack[i]) cnt[i]++;
        k++;
      end
    end
    check("fair_total", 32'(k), 32'd12);
    for (int i = 0; i < NREQ; i++) check("fair_count", 32'(cnt[i]), 32'd4);
    req = '0;
    tick();
    tick();
    check("fair_idle_psel", 32'(psel), 32'd0);

    // Sole requester repeating
    set_req(0, 1'b1, 12'h030, 32'hAB);
    req = 3'b001;
    prev_pen = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      tick();
      check("sole_psel", 32'(psel), 32'((c % 3) != 0));
      check("sole_penable", 32'(penable), 32'((c % 3) == 2));
      check("sole_pen_consec", 32'(prev_pen & penable), 32'd0);
      prev_pen = penable;
      if (c == 8) req = '0;
    end

    // Reset in the middle of ACCESS
    set_req(1, 1'b0, 12'h008, 32'h0);
    req = 3'b010;
    tick();
    tick();
    check("rstmid_ack_before", 32'(ack), 32'b010);
    presetn = 1'b0;
    #1;
    check("rstmid_psel", 32'(psel), 32'd0);
    check("rstmid_penable", 32'(penable), 32'd0);
    check("rstmid_ack", 32'(ack), 32'd0);
    req = '0;
    @(negedge pclk);
    presetn = 1'b1;
    set_req(0, 1'b1, 12'h00C, 32'h77);
    req = 3'b011;
    tick();
    check("rstmid_prio_grant", 32'(grant), 32'b001);
    check("rstmid_prio_psel", 32'(psel), 32'd1);
    tick();
    req = 3'b010;
    tick();
    tick();
    req = '0;
    tick();
    tick();

    // Randomized traffic against the transaction-level model
    do_reset();
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'hC1 + 32'(i);
    m_owner = -1; m_phase = 0; m_last = NREQ - 1;
    m_write = 1'b0; m_addr = '0; m_wdata = '0;
    pend = '0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      tick();
      // Model the edge just taken, using the request inputs that were presented before it
      just_acked = -1;
      if (m_owner >= 0 && m_phase == 1) begin
        m_phase = 2;
      end else begin
        if (m_owner >= 0) begin
          just_acked = m_owner;
          if (m_write) ref_mem[m_addr[5:2]] = m_wdata;
        end
        winner = -1;
        for (int s = 1; s <= NREQ; s++) begin
          cidx = (m_last + s) % NREQ;
          if (winner < 0 && req[cidx] && cidx != just_acked) winner = cidx;
        end
        if (winner >= 0) begin
          m_owner = winner; m_phase = 1; m_last = winner;
          m_write = req_write[winner];
          m_addr  = req_addr[winner*AW +: AW];
          m_wdata = req_wdata[winner*DW +: DW];
        end else begin
          m_owner = -1; m_phase = 0;
        end
      end
      exp_oh = '0;
      if (m_owner >= 0) exp_oh[m_owner] = 1'b1;
      check("rnd_psel", 32'(psel), 32'(m_owner >= 0));
      check("rnd_penable", 32'(penable), 32'(m_phase == 2));
      check("rnd_grant", 32'(grant), 32'(exp_oh));
      check("rnd_ack", 32'(ack), (m_phase == 2) ? 32'(exp_oh) : 32'd0);
      check("rnd_paddr", 32'(paddr), 32'(m_addr));
      check("rnd_pwrite", 32'(pwrite), 32'(m_write));
      check("rnd_pwdata", pwdata, m_wdata);
      if (m_phase == 2 && !m_write) check("rnd_rdata", rdata, ref_mem[m_addr[5:2]]);
      // Requesters: clear after ack (cycle after), otherwise maybe raise a new request
      if (just_acked >= 0) pend[just_acked] = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          set_req(i, 1'($urandom_range(0, 1)), {6'd0, 4'($urandom_range(0, 15)), 2'b00}, $urandom);
        end
      end
      req = pend;
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
